debug_dump_sequencer: RTL and testbench
=======================================

DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 SHALL have parameter BYTE, default 8, UART byte width.
REQ-002 SHALL have parameter DWORD, default 32, register and PC word width.
REQ-003 SHALL have parameter ADDR, default 7, data-memory address width (128 bytes).
REQ-004 SHALL have parameter RB_ADDR, default 5, register-bank address width (32 registers).
REQ-005 SHALL have one clock and a synchronous, active-high reset: i_clock  input  1  rising-edge clock; i_reset  input  1  synchronous active-high reset.
REQ-006 SHALL have i_start  input  1  one-cycle dump request.
REQ-007 SHALL have i_tx_done  input  1  UART transmit-complete tick.
REQ-008 SHALL have i_pc_value  input  DWORD  current PC.
REQ-009 SHALL have i_rb_data  input  DWORD  register-bank read data, valid 1 cycle after address.
REQ-010 SHALL have i_dm_data  input  BYTE  data-memory byte, valid 1 cycle after address.
REQ-011 SHALL have o_rb_addr  output  RB_ADDR; o_rb_enable, o_rb_read_enable  output  1 each.
REQ-012 SHALL have o_dm_addr  output  ADDR; o_dm_enable, o_dm_read_enable  output  1 each.
REQ-013 SHALL have o_tx_data  output  BYTE; o_tx_start  output  1  transmit request pulse.
REQ-014 SHALL have o_busy  output  1  dump in progress; o_done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, PC_SEND, PC_WAIT, RB_READ, RB_LATCH, RB_SEND, RB_WAIT, DM_READ, DM_LATCH, DM_SEND, DM_WAIT, DONE.
REQ-016 SHALL, on i_start in IDLE, capture i_pc_value into an internal word, clear counters, go to PC_SEND; o_busy=1 from the next cycle.
REQ-017 SHALL ignore i_start whenever not in IDLE.
REQ-018 SHALL send words least-significant byte first; byte index 0..3.
REQ-019 SHALL, in every *_SEND state, drive o_tx_data and pulse o_tx_start for exactly one cycle, then go to *_WAIT.
REQ-020 SHALL hold o_tx_data stable from the *_SEND cycle until i_tx_done is seen in *_WAIT.
REQ-021 SHALL ignore i_tx_done outside *_WAIT states.
REQ-022 SHALL, in PC_WAIT on i_tx_done, advance byte index; after byte 3 go to RB_READ with o_rb_addr=0.
REQ-023 SHALL, in RB_READ, assert o_rb_enable and o_rb_read_enable for one cycle; RB_LATCH captures i_rb_data.
REQ-024 SHALL send 4 bytes per register; after byte 3 of register 31 go to DM_READ with o_dm_addr=0, otherwise increment o_rb_addr and return to RB_READ.
REQ-025 SHALL, in DM_READ, assert o_dm_enable and o_dm_read_enable for one cycle; DM_LATCH captures i_dm_data; one byte sent per address.
REQ-026 SHALL, after address 127 completes (no wrap to 0), go to DONE; DONE pulses o_done one cycle, drops o_busy, returns to IDLE.
REQ-027 SHALL emit exactly 260 bytes per dump without checksum: 4 PC, 128 register, 128 memory.
REQ-028 SHALL keep enables and o_tx_start low in all states not listed above.

Reset
REQ-029 SHALL, on i_reset at any clock edge, including mid-dump, enter IDLE with every output 0, counters and latched words 0.
REQ-030 SHALL not resume an aborted dump; a new i_start is required.

Configuration
REQ-031 SHALL, with DEBUG_DUMP_CHECKSUM_EN defined, add state CK_SEND/CK_WAIT after memory: send one byte equal to XOR of all 260 prior bytes, total 261 bytes, then DONE.
REQ-032 SHALL, without DEBUG_DUMP_CHECKSUM_EN, contain no checksum logic and go from last memory byte directly to DONE.

Structure
REQ-033 SHALL take the state encoding, byte counts (4, 32, 128) and the checksum width from a shared package debug_pkg.
REQ-034 SHALL be one module; optional sub-module word_serializer (DWORD word to LSB-first bytes with index) is permitted.

Verification
REQ-035 SHALL cover: PC=0x0000_1234, regs zero, mem zero, i_tx_done 3 cycles after each start -> first 4 bytes 0x34,0x12,0x00,0x00; 260 o_tx_start pulses; one o_done.
REQ-036 SHALL cover: reg n = 0xA0B0C000+n -> bytes 5..8 = 0x00,0xC0,0xB0,0xA0; register-31 bytes 0x1F,0xC0,0xB0,0xA0.
REQ-037 SHALL cover: mem[a]=a -> last 128 bytes 0x00..0x7F in order; o_dm_addr never exceeds 127.
REQ-038 SHALL cover: i_start pulsed while busy and spurious i_tx_done in SEND/READ states -> byte stream and count unchanged.
REQ-039 SHALL cover: i_reset asserted after byte 50 -> next cycle o_busy=0, o_tx_start=0, all addresses 0; fresh i_start restarts from PC byte 0.
REQ-040 SHALL cover, with DEBUG_DUMP_CHECKSUM_EN: PC=0x01, all else 0 -> byte 261 = 0x01 and o_done after it.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings and byte counts for the debug dump sequencer.
// DEBUG_DUMP_CHECKSUM_EN adds the trailing XOR checksum states.
package debug_pkg;

  localparam int PC_BYTES = 4;
  localparam int RB_COUNT = 32;
  localparam int DM_COUNT = 128;
  localparam int CK_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE,
    PC_SEND,
    PC_WAIT,
    RB_READ,
    RB_LATCH,
    RB_SEND,
    RB_WAIT,
    DM_READ,
    DM_LATCH,
    DM_SEND,
    DM_WAIT,
`ifdef DEBUG_DUMP_CHECKSUM_EN
    CK_SEND,
    CK_WAIT,
`endif
    DONE
  } state_t;

  function automatic logic is_send(state_t s);
    return (s == PC_SEND) || (s == RB_SEND) || (s == DM_SEND);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Picks one byte of a word, least-significant byte at index 0.
// Pure combinational slice used by the dump sequencer.
module word_serializer #(
  parameter int BYTE  = 8,
  parameter int DWORD = 32,
  parameter int IDXW  = $clog2(DWORD / BYTE)
) (
  input  logic [DWORD-1:0] word,
  input  logic [IDXW-1:0]  idx,
  output logic [BYTE-1:0]  byte_out
);

  always_comb begin
    byte_out = word[idx*BYTE +: BYTE];
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, register bank and data memory over a UART, LSB first.
// DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte.
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int ADDR    = 7,
  parameter int RB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_tx_done,
  input  logic [DWORD-1:0]   i_pc_value,
  input  logic [DWORD-1:0]   i_rb_data,
  input  logic [BYTE-1:0]    i_dm_data,
  output logic [RB_ADDR-1:0] o_rb_addr,
  output logic               o_rb_enable,
  output logic               o_rb_read_enable,
  output logic [ADDR-1:0]    o_dm_addr,
  output logic               o_dm_enable,
  output logic               o_dm_read_enable,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IDXW = $clog2(PC_BYTES);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PC_BYTES - 1);
  localparam logic [RB_ADDR-1:0] RB_LAST = RB_ADDR'(RB_COUNT - 1);
  localparam logic [ADDR-1:0] DM_LAST = ADDR'(DM_COUNT - 1);

  state_t state, state_n;
  logic [IDXW-1:0]    idx, idx_n;
  logic [RB_ADDR-1:0] rb_addr, rb_n;
  logic [ADDR-1:0]    dm_addr, dm_n;
  logic [DWORD-1:0]   word, word_n;
  logic [BYTE-1:0]    ser_byte;
  logic               rb_en, dm_en, tx_start, done;

  word_serializer #(
    .BYTE  (BYTE),
    .DWORD (DWORD),
    .IDXW  (IDXW)
  ) u_ser (
    .word     (word),
    .idx      (idx),
    .byte_out (ser_byte)
  );

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [CK_WIDTH-1:0] ck, ck_n;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      idx     <= '0;
      rb_addr <= '0;
      dm_addr <= '0;
      word    <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      ck      <= '0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      rb_addr <= rb_n;
      dm_addr <= dm_n;
      word    <= word_n;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      ck      <= ck_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rb_n     = rb_addr;
    dm_n     = dm_addr;
    word_n   = word;
    rb_en    = 1'b0;
    dm_en    = 1'b0;
    tx_start = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n = PC_SEND;
          word_n  = i_pc_value;
          idx_n   = '0;
          rb_n    = '0;
          dm_n    = '0;
        end
      end
      PC_SEND: begin
        tx_start = 1'b1;
        state_n  = PC_WAIT;
      end
      PC_WAIT: begin
        if (i_tx_done) begin
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            rb_n    = '0;
            state_n = RB_READ;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = PC_SEND;
          end
        end
      end
      RB_READ: begin
        rb_en   = 1'b1;
        state_n = RB_LATCH;
      end
      RB_LATCH: begin
        word_n  = i_rb_data;
        idx_n   = '0;
        state_n = RB_SEND;
      end
      RB_SEND: begin
        tx_start = 1'b1;
        state_n  = RB_WAIT;
      end
      RB_WAIT: begin
        if (i_tx_done) begin
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (rb_addr == RB_LAST) begin
              dm_n    = '0;
              state_n = DM_READ;
            end else begin
              rb_n    = rb_addr + 1'b1;
              state_n = RB_READ;
            end
          end else begin
            idx_n   = idx + 1'b1;
            state_n = RB_SEND;
          end
        end
      end
      DM_READ: begin
        dm_en   = 1'b1;
        state_n = DM_LATCH;
      end
      DM_LATCH: begin
        word_n  = DWORD'(i_dm_data);
        idx_n   = '0;
        state_n = DM_SEND;
      end
      DM_SEND: begin
        tx_start = 1'b1;
        state_n  = DM_WAIT;
      end
      DM_WAIT: begin
        // Stop at the last address rather than wrapping the counter.
        if (i_tx_done) begin
          if (dm_addr == DM_LAST) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
            state_n = CK_SEND;
`else
            state_n = DONE;
`endif
          end else begin
            dm_n    = dm_addr + 1'b1;
            state_n = DM_READ;
          end
        end
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      CK_SEND: begin
        tx_start = 1'b1;
        state_n  = CK_WAIT;
      end
      CK_WAIT: begin
        if (i_tx_done) state_n = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Fold every data byte in as it is sent; cleared on each new dump.
  always_comb begin
    ck_n = ck;
    if (state == IDLE && i_start)
      ck_n = '0;
    else if (is_send(state))
      ck_n = ck ^ CK_WIDTH'(ser_byte);
  end

  always_comb begin
    o_tx_data = ser_byte;
    if (state == CK_SEND || state == CK_WAIT)
      o_tx_data = BYTE'(ck);
  end
`else
  always_comb begin
    o_tx_data = ser_byte;
  end
`endif

  always_comb begin
    o_rb_addr        = rb_addr;
    o_rb_enable      = rb_en;
    o_rb_read_enable = rb_en;
    o_dm_addr        = dm_addr;
    o_dm_enable      = dm_en;
    o_dm_read_enable = dm_en;
    o_tx_start       = tx_start;
    o_done           = done;
    o_busy           = (state != IDLE) && (state != DONE);
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: scenario table plus spot checks.
// Reset abort and no-resume handled as a hand-written sequence.
module tb_debug_dump_sequencer;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int EXP_LEN = 261;
`else
  localparam int EXP_LEN = 260;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [31:0] i_pc_value = '0;
  logic [31:0] i_rb_data = '0;
  logic [7:0]  i_dm_data = '0;
  logic [4:0]  o_rb_addr;
  logic        o_rb_enable, o_rb_read_enable;
  logic [6:0]  o_dm_addr;
  logic        o_dm_enable, o_dm_read_enable;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_busy, o_done;

  debug_dump_sequencer dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_tx_done        (i_tx_done),
    .i_pc_value       (i_pc_value),
    .i_rb_data        (i_rb_data),
    .i_dm_data        (i_dm_data),
    .o_rb_addr        (o_rb_addr),
    .o_rb_enable      (o_rb_enable),
    .o_rb_read_enable (o_rb_read_enable),
    .o_dm_addr        (o_dm_addr),
    .o_dm_enable      (o_dm_enable),
    .o_dm_read_enable (o_dm_read_enable),
    .o_tx_data        (o_tx_data),
    .o_tx_start       (o_tx_start),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] pc;
    bit          reg_pat;
    bit          mem_pat;
    bit          noise;
  } scen_t;

  typedef struct {
    int         scen;
    int         idx;
    logic [7:0] exp;
  } spot_t;

  int total = 0;
  int bad = 0;

  logic [31:0] regs [32];
  logic [7:0]  mem  [128];
  logic [7:0]  cap  [$];
  logic [7:0]  expq [$];

  bit          noise = 0;
  int          cnt = 0;
  bit          spur = 0;
  bit          rb_pv = 0, dm_pv = 0;
  logic [31:0] rb_pend = '0;
  logic [7:0]  dm_pend = '0;
  logic [7:0]  held = '0;
  int          done_cnt = 0, rb_reads = 0, dm_reads = 0;
  int          ord_err = 0, stab_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
    i_start   = 1'b0;
    i_tx_done = 1'b0;
    if (rb_pv) i_rb_data = rb_pend;
    if (dm_pv) i_dm_data = dm_pend;
    rb_pv = o_rb_enable && o_rb_read_enable;
    dm_pv = o_dm_enable && o_dm_read_enable;
    if (rb_pv) begin
      rb_pend = regs[o_rb_addr];
      if (o_rb_addr != 5'(rb_reads) || rb_reads >= 32) ord_err++;
      rb_reads++;
      if (noise) i_start = 1'b1;
    end
    if (dm_pv) begin
      dm_pend = mem[o_dm_addr];
      if (o_dm_addr != 7'(dm_reads) || dm_reads >= 128) ord_err++;
      dm_reads++;
    end
    if (o_done) done_cnt++;
    if (spur) begin
      i_tx_done = 1'b1;
      spur = 0;
    end
    if (cnt > 0) begin
      if (o_tx_data !== held) stab_err++;
      cnt--;
      if (cnt == 0) begin
        i_tx_done = 1'b1;
        spur = noise;
      end
    end
    if (o_tx_start) begin
      cap.push_back(o_tx_data);
      held = o_tx_data;
      cnt = 3;
      if (noise) i_start = 1'b1;
    end
  endtask

  task automatic setup(input scen_t s);
    i_pc_value = s.pc;
    for (int n = 0; n < 32; n++)
      regs[n] = s.reg_pat ? 32'hA0B0C000 + 32'(n) : 32'h0;
    for (int a = 0; a < 128; a++)
      mem[a] = s.mem_pat ? 8'(a) : 8'h0;
    expq.delete();
    for (int b = 0; b < 4; b++) expq.push_back(8'(s.pc >> (8 * b)));
    for (int n = 0; n < 32; n++)
      for (int b = 0; b < 4; b++) expq.push_back(8'(regs[n] >> (8 * b)));
    for (int a = 0; a < 128; a++) expq.push_back(mem[a]);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h0;
      foreach (expq[i]) x ^= expq[i];
      expq.push_back(x);
    end
`endif
  endtask

  task automatic clear_trackers();
    cap.delete();
    done_cnt = 0;
    rb_reads = 0;
    dm_reads = 0;
    ord_err = 0;
    stab_err = 0;
    cnt = 0;
    spur = 0;
  endtask

  task automatic run_dump(input bit nz);
    int guard;
    clear_trackers();
    noise = nz;
    i_start = 1'b1;
    step();
    chk("busy_after_start", 32'(o_busy), 32'd1);
    guard = 0;
    while (done_cnt == 0 && guard < 6000) begin
      step();
      guard++;
    end
    chk("dump_timeout", 32'(guard < 6000), 32'd1);
    noise = 0;
    for (int k = 0; k < 8; k++) step();
    chk("byte_count", 32'(cap.size()), 32'(EXP_LEN));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("rb_reads", 32'(rb_reads), 32'd32);
    chk("dm_reads", 32'(dm_reads), 32'd128);
    chk("addr_order", 32'(ord_err), 32'd0);
    chk("tx_data_hold", 32'(stab_err), 32'd0);
    chk("busy_end", 32'(o_busy), 32'd0);
  endtask

  task automatic cmp_stream(input string name);
    int first;
    first = -1;
    for (int i = 0; i < EXP_LEN && i < cap.size(); i++)
      if (first < 0 && cap[i] !== expq[i]) first = i;
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: byte %0d got %0h want %0h",
               name, first, cap[first], expq[first]);
    end
  endtask

  scen_t scens [$];
  spot_t spots [$];

  initial begin
    scens.push_back('{32'h0000_1234, 1'b0, 1'b0, 1'b0});
    scens.push_back('{32'h0000_1234, 1'b1, 1'b1, 1'b0});
    scens.push_back('{32'h0000_1234, 1'b1, 1'b1, 1'b1});
`ifdef DEBUG_DUMP_CHECKSUM_EN
    scens.push_back('{32'h0000_0001, 1'b0, 1'b0, 1'b0});
`endif
    spots.push_back('{0, 0, 8'h34});
    spots.push_back('{0, 1, 8'h12});
    spots.push_back('{0, 2, 8'h00});
    spots.push_back('{0, 3, 8'h00});
    spots.push_back('{1, 4, 8'h00});
    spots.push_back('{1, 5, 8'hC0});
    spots.push_back('{1, 6, 8'hB0});
    spots.push_back('{1, 7, 8'hA0});
    spots.push_back('{1, 128, 8'h1F});
    spots.push_back('{1, 129, 8'hC0});
    spots.push_back('{1, 130, 8'hB0});
    spots.push_back('{1, 131, 8'hA0});
    spots.push_back('{1, 132, 8'h00});
    spots.push_back('{1, 259, 8'h7F});
    spots.push_back('{2, 5, 8'hC0});
    spots.push_back('{2, 128, 8'h1F});
    spots.push_back('{2, 259, 8'h7F});
`ifdef DEBUG_DUMP_CHECKSUM_EN
    spots.push_back('{3, 0, 8'h01});
    spots.push_back('{3, 260, 8'h01});
`endif

    for (int k = 0; k < 3; k++) step();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_rb_addr", 32'(o_rb_addr), 32'd0);
    chk("rst_dm_addr", 32'(o_dm_addr), 32'd0);
    chk("rst_enables", 32'({o_rb_enable, o_rb_read_enable,
                            o_dm_enable, o_dm_read_enable}), 32'd0);
    i_reset = 1'b0;
    step();

    for (int s = 0; s < scens.size(); s++) begin
      setup(scens[s]);
      run_dump(scens[s].noise);
      cmp_stream($sformatf("stream_s%0d", s));
      foreach (spots[j])
        if (spots[j].scen == s)
          chk($sformatf("spot_s%0d_b%0d", s, spots[j].idx),
              32'(cap.size() > spots[j].idx ? cap[spots[j].idx] : 8'hxx),
              32'(spots[j].exp));
    end

    // Abort after byte 50, confirm idle outputs and no resume.
    setup(scens[1]);
    clear_trackers();
    i_start = 1'b1;
    step();
    begin
      int guard;
      guard = 0;
      while (cap.size() < 50 && guard < 2000) begin
        step();
        guard++;
      end
      chk("abort_reach50", 32'(cap.size()), 32'd50);
    end
    i_reset = 1'b1;
    step();
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_tx_start", 32'(o_tx_start), 32'd0);
    chk("abort_rb_addr", 32'(o_rb_addr), 32'd0);
    chk("abort_dm_addr", 32'(o_dm_addr), 32'd0);
    chk("abort_tx_data", 32'(o_tx_data), 32'd0);
    i_reset = 1'b0;
    cnt = 0;
    spur = 0;
    for (int k = 0; k < 30; k++) step();
    chk("no_resume_busy", 32'(o_busy), 32'd0);
    chk("no_resume_bytes", 32'(cap.size()), 32'd50);
    run_dump(1'b0);
    cmp_stream("stream_restart");
    chk("restart_b0", 32'(cap.size() > 0 ? cap[0] : 8'hxx), 32'h34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
